// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the uart_txrx block.
//   rx_state_t / tx_state_t : receiver and transmitter FSM encodings
//   calc_clks_per_bit       : rounded clock-cycles-per-bit, floor of 2
//   calc_half_load          : reload value used to reach the start-bit mid-point
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    int unsigned cpb;
    cpb = (clk_hz + baud / 2) / baud;
    if (cpb < 2) cpb = 2;
    return cpb;
  endfunction

  // The receiver sees the line two synchronizer stages plus one edge-detect
  // stage late. Shortening the half-bit wait by one cycle pulls every sample
  // back toward the true bit centre.
  function automatic int unsigned calc_half_load(input int unsigned cpb);
    int unsigned half;
    half = cpb / 2;
    return (half >= 2) ? (half - 2) : 0;
  endfunction

endpackage

// File: rtl/uart_txrx_if.sv
// uart_txrx_if: parallel-side handshake of the uart_txrx block.
//   i_tx_rdy / i_tx_data : transmit start strobe and byte
//   o_tx_busy            : transmitter occupied
//   o_rx_data / o_rx_valid : last good received byte and its available flag
//   o_rx_frame_err       : one-cycle bad-stop-bit pulse (only with UART_FRAME_ERR_EN)
// Modports: slave = the UART, master = the user logic.
interface uart_txrx_if;
  logic       i_tx_rdy;
  logic [7:0] i_tx_data;
  logic       o_tx_busy;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
`ifdef UART_FRAME_ERR_EN
  logic       o_rx_frame_err;
`endif

  modport slave (
    input  i_tx_rdy,
    input  i_tx_data,
    output o_tx_busy,
    output o_rx_data,
`ifdef UART_FRAME_ERR_EN
    output o_rx_frame_err,
`endif
    output o_rx_valid
  );

  modport master (
    output i_tx_rdy,
    output i_tx_data,
    input  o_tx_busy,
    input  o_rx_data,
`ifdef UART_FRAME_ERR_EN
    input  o_rx_frame_err,
`endif
    input  o_rx_valid
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: down-counter timing one bit period.
//   i_clk, i_rst     : clock, asynchronous active-low reset
//   i_load_full      : reload for a full bit period (CLKS_PER_BIT cycles to o_done)
//   i_load_half      : reload for the start-bit mid-point wait
//   o_done           : counter has reached zero (held there until reloaded)
// i_load_full has priority over i_load_half.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load_half,
  input  logic i_load_full,
  output logic o_done
);

  localparam int unsigned W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL_LOAD = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_LOAD = W'(calc_half_load(CLKS_PER_BIT));

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_load_full) begin
      r_cnt <= FULL_LOAD;
    end else if (i_load_half) begin
      r_cnt <= HALF_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/uart_txrx.sv
// uart_txrx: independent 8N1 UART receiver and transmitter.
//   Parameters: CLOCK_HZ (input clock, Hz), BAUD_RATE (bits per second).
//   i_clk, i_rst : clock (rising edge), asynchronous active-low reset
//   i_uart_rx    : asynchronous serial input, idle high
//   o_uart_tx    : serial output, idle high
//   bus          : uart_txrx_if.slave (tx strobe/data/busy, rx data/valid)
// Optional build macro UART_FRAME_ERR_EN adds bus.o_rx_frame_err, a one-cycle
// pulse when a stop bit is sampled low; without it bad frames drop silently.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_uart_rx,
  output logic           o_uart_tx,
  uart_txrx_if.slave     bus
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLOCK_HZ, BAUD_RATE);

  // ---------------------------------------------------------------- receiver
  logic       r_rx_s1, r_rx_s2, r_rx_d;
  rx_state_t  r_rx_state;
  logic [7:0] r_rx_shift;
  logic [2:0] r_rx_bitcnt;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
`ifdef UART_FRAME_ERR_EN
  logic       r_rx_frame_err;
`endif

  logic w_rx_fall;
  logic w_rx_done;
  logic w_rx_load_half;
  logic w_rx_load_full;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= i_uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign w_rx_fall      = r_rx_d & ~r_rx_s2;
  assign w_rx_load_half = (r_rx_state == RX_IDLE) && w_rx_fall;
  assign w_rx_load_full = w_rx_done &&
                          (((r_rx_state == RX_START) && !r_rx_s2) ||
                           (r_rx_state == RX_DATA));

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load_half (w_rx_load_half),
    .i_load_full (w_rx_load_full),
    .o_done      (w_rx_done)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_state  <= RX_IDLE;
      r_rx_shift  <= '0;
      r_rx_bitcnt <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      r_rx_frame_err <= 1'b0;
`endif
    end else begin
`ifdef UART_FRAME_ERR_EN
      r_rx_frame_err <= 1'b0;
`endif
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (w_rx_done) begin
            if (!r_rx_s2) begin
              r_rx_state  <= RX_DATA;
              r_rx_bitcnt <= '0;
              r_rx_valid  <= 1'b0;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (w_rx_done) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bitcnt == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bitcnt <= r_rx_bitcnt + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (w_rx_done) begin
            if (r_rx_s2) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_WAIT_HIGH;
`ifdef UART_FRAME_ERR_EN
              r_rx_frame_err <= 1'b1;
`endif
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (r_rx_s2) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.o_rx_data  = r_rx_data;
  assign bus.o_rx_valid = r_rx_valid;
`ifdef UART_FRAME_ERR_EN
  assign bus.o_rx_frame_err = r_rx_frame_err;
`endif

  // ------------------------------------------------------------- transmitter
  tx_state_t  r_tx_state;
  logic [7:0] r_tx_shift;
  logic [2:0] r_tx_bitcnt;
  logic       r_tx_line;
  logic       r_tx_busy;

  logic w_tx_done;
  logic w_tx_accept;
  logic w_tx_load_full;

  assign w_tx_accept    = (r_tx_state == TX_IDLE) && !r_tx_busy && bus.i_tx_rdy;
  assign w_tx_load_full = w_tx_accept ||
                          (w_tx_done && ((r_tx_state == TX_START) ||
                                         (r_tx_state == TX_DATA)));

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load_half (1'b0),
    .i_load_full (w_tx_load_full),
    .o_done      (w_tx_done)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx_state  <= TX_IDLE;
      r_tx_shift  <= '0;
      r_tx_bitcnt <= '0;
      r_tx_line   <= 1'b1;
      r_tx_busy   <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_accept) begin
            r_tx_shift  <= bus.i_tx_data;
            r_tx_bitcnt <= '0;
            r_tx_line   <= 1'b0;
            r_tx_busy   <= 1'b1;
            r_tx_state  <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_done) begin
            r_tx_line  <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          // The line always carries shift[0]; advancing puts the next bit there.
          if (w_tx_done) begin
            if (r_tx_bitcnt == 3'd7) begin
              r_tx_line  <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_line   <= r_tx_shift[1];
              r_tx_shift  <= {1'b0, r_tx_shift[7:1]};
              r_tx_bitcnt <= r_tx_bitcnt + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (w_tx_done) begin
            r_tx_busy  <= 1'b0;
            r_tx_state <= TX_IDLE;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign o_uart_tx     = r_tx_line;
  assign bus.o_tx_busy = r_tx_busy;

endmodule

// File: tb/tb_uart_txrx.sv
`timescale 1ns/1ps
module tb_uart_txrx;

  localparam int CPB = 10;

  logic clk;
  logic rst_n;
  logic rx_drv;
  logic loop_en;
  logic uart_tx;
  logic rx_line;

  uart_txrx_if bus();

  assign rx_line = loop_en ? uart_tx : rx_drv;

  uart_txrx #(.CLOCK_HZ(1_000_000), .BAUD_RATE(100_000)) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_uart_rx (rx_line),
    .o_uart_tx (uart_tx),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

`ifdef UART_FRAME_ERR_EN
  int ferr_cnt = 0;
  always @(negedge clk) if (bus.o_rx_frame_err === 1'b1) ferr_cnt++;
`endif

  logic tx_samp   [0:109];
  logic busy_samp [0:109];
  int   busy_cnt;

  // Issue a transmit request and record 110 cycles of line/busy, starting with
  // the first cycle the start bit should be visible. Optionally pulse a second
  // request inj_at cycles into the frame.
  task automatic tx_run(input logic [7:0] d, input int inj_at, input logic [7:0] inj_d);
    @(negedge clk);
    bus.i_tx_rdy  = 1'b1;
    bus.i_tx_data = d;
    @(negedge clk);
    bus.i_tx_rdy  = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 110; i++) begin
      tx_samp[i]   = uart_tx;
      busy_samp[i] = bus.o_tx_busy;
      if (bus.o_tx_busy === 1'b1) busy_cnt++;
      if (i == inj_at) begin
        bus.i_tx_rdy  = 1'b1;
        bus.i_tx_data = inj_d;
      end else begin
        bus.i_tx_rdy  = 1'b0;
      end
      @(negedge clk);
    end
    bus.i_tx_rdy = 1'b0;
  endtask

  // Drive start, data bits and the first half of the stop bit; returns at the
  // stop-bit mid-point with the line left at the stop level.
  task automatic rx_send(input logic [7:0] d, input logic stopb);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stopb;
    repeat (CPB / 2) @(negedge clk);
  endtask

  task automatic rx_good(input logic [7:0] d, input string tag);
    logic seen;
    rx_send(d, 1'b1);
    check_eq({tag, "_valid_at_mid"}, {31'd0, bus.o_rx_valid}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 2 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_rx_valid === 1'b1) seen = 1'b1;
    end
    check_eq({tag, "_valid_within2"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_data"}, {24'd0, bus.o_rx_data}, {24'd0, d});
    repeat (CPB) @(negedge clk);
  endtask

  logic [9:0] exp_a5;
  logic [7:0] dec;
  int         match;
  int         wait_cnt;

  initial begin
    rst_n = 1'b0;
    rx_drv = 1'b1;
    loop_en = 1'b0;
    bus.i_tx_rdy = 1'b0;
    bus.i_tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_line", {31'd0, uart_tx}, 32'd1);
    check_eq("rst_tx_busy", {31'd0, bus.o_tx_busy}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, bus.o_rx_valid}, 32'd0);
    check_eq("rst_rx_data", {24'd0, bus.o_rx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // TX 0xA5: start, 1,0,1,0,0,1,0,1, stop
    exp_a5 = 10'b1101001010;
    tx_run(8'hA5, -1, 8'h00);
    for (int b = 0; b < 10; b++) begin
      match = 0;
      for (int c = 0; c < CPB; c++)
        if (tx_samp[b*CPB + c] === exp_a5[b]) match++;
      check_eq($sformatf("tx_a5_bit%0d_cycles", b), match, CPB);
    end
    check_eq("tx_a5_busy_cycles", busy_cnt, 100);
    check_eq("tx_a5_busy_last", {31'd0, busy_samp[99]}, 32'd1);
    check_eq("tx_a5_busy_drop", {31'd0, busy_samp[100]}, 32'd0);
    match = 0;
    for (int c = 100; c < 110; c++) if (tx_samp[c] === 1'b1) match++;
    check_eq("tx_a5_idle_high", match, 10);

    // RX good frame
    rx_good(8'h3C, "rx_3c");

    // 3-cycle low glitch must be rejected
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("glitch_valid", {31'd0, bus.o_rx_valid}, 32'd1);
    check_eq("glitch_data", {24'd0, bus.o_rx_data}, 32'h3C);

    // Bad stop bit: byte discarded, line held low then released
`ifdef UART_FRAME_ERR_EN
    wait_cnt = ferr_cnt;
`endif
    rx_send(8'h55, 1'b0);
    repeat (15) @(negedge clk);
    rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("bad_stop_data", {24'd0, bus.o_rx_data}, 32'h3C);
    check_eq("bad_stop_valid", {31'd0, bus.o_rx_valid}, 32'd0);
`ifdef UART_FRAME_ERR_EN
    check_eq("bad_stop_ferr_pulses", ferr_cnt - wait_cnt, 1);
`endif

    // Receiver recovers after the bad frame
    rx_good(8'hC3, "rx_c3");

    // Second request while busy is ignored
    tx_run(8'h11, 30, 8'h22);
    dec = '0;
    for (int b = 0; b < 8; b++) dec[b] = tx_samp[(b + 1)*CPB + CPB/2];
    check_eq("tx_busy_ignore_byte", {24'd0, dec}, 32'h11);
    check_eq("tx_busy_ignore_start", {31'd0, tx_samp[5]}, 32'd0);
    check_eq("tx_busy_ignore_stop", {31'd0, tx_samp[95]}, 32'd1);
    check_eq("tx_busy_ignore_cycles", busy_cnt, 100);

    // Loopback: TX and RX running together
    loop_en = 1'b1;
    @(negedge clk);
    bus.i_tx_rdy = 1'b1;
    bus.i_tx_data = 8'h96;
    @(negedge clk);
    bus.i_tx_rdy = 1'b0;
    wait_cnt = 0;
    while (bus.o_tx_busy === 1'b1 && wait_cnt < 150) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_eq("loop_tx_done_in_time", {31'd0, (wait_cnt < 150)}, 32'd1);
    repeat (5) @(negedge clk);
    check_eq("loop_rx_valid", {31'd0, bus.o_rx_valid}, 32'd1);
    check_eq("loop_rx_data", {24'd0, bus.o_rx_data}, 32'h96);
    loop_en = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame of zeros (line is low at that point)
    @(negedge clk);
    bus.i_tx_rdy = 1'b1;
    bus.i_tx_data = 8'h00;
    @(negedge clk);
    bus.i_tx_rdy = 1'b0;
    repeat (35) @(negedge clk);
    check_eq("midtx_line_low", {31'd0, uart_tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("midtx_rst_line", {31'd0, uart_tx}, 32'd1);
    check_eq("midtx_rst_busy", {31'd0, bus.o_tx_busy}, 32'd0);
    check_eq("midtx_rst_rx_data", {24'd0, bus.o_rx_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("post_rst_line", {31'd0, uart_tx}, 32'd1);
    check_eq("post_rst_busy", {31'd0, bus.o_tx_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
